uart_tx_sched: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rr_pick.sv | 36 +++
 rtl/uart_tx_sched.sv | 117 +++++++++++
 tb/tb_uart_tx_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// State encoding, default watchdog limit and one-hot helper.
package uart_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } sched_state_t;

  localparam int TIMEOUT_DEF = 4096;

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority pick: first set request at or above ptr,
// wrapping modulo N_REQ.
module uart_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     found
);

  localparam int IW = $clog2(N_REQ);

  function automatic logic [IW-1:0] rot(
    input logic [IW-1:0] p,
    input int            off
  );
    int s;
    s = int'(p) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  // Scan from the far end so the nearest offset wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[rot(ptr, i)]) begin
        idx   = rot(ptr, i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin burst scheduler sharing one UART transmitter
// between N_REQ byte producers, with a transmit watchdog.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_enb,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               err_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_WAIT = WAIT;

  logic [0:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [BW-1:0] burst_cnt;
  logic [WW-1:0] wd_cnt;

  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic [N_REQ-1:0] pick_oh;
  logic [7:0]       pick_data;
  logic [7:0]       own_data;
  logic [IW-1:0]    nxt_ptr;
  logic             wd_expire;
  logic             cont;

  uart_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr),
    .idx  (pick_idx),
    .found(pick_found)
  );

  assign pick_oh   = N_REQ'(onehot(3'(pick_idx)));
  assign pick_data = req_data[pick_idx*8 +: 8];
  assign own_data  = req_data[owner*8 +: 8];
  assign nxt_ptr   = (owner == IW'(N_REQ - 1)) ? '0
                   : owner + 1'b1;
  assign wd_expire = (wd_cnt == WW'(TIMEOUT - 1));
  assign cont      = req_valid[owner]
                   && (burst_cnt < BW'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner       <= '0;
      burst_cnt   <= '0;
      wd_cnt      <= '0;
      req_ready   <= '0;
      tx_enb      <= 1'b0;
      tx_data     <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_enb      <= 1'b0;
      req_ready   <= '0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state     <= ST_WAIT;
            busy      <= 1'b1;
            owner     <= pick_idx;
            grant     <= pick_oh;
            req_ready <= pick_oh;
            tx_enb    <= 1'b1;
            tx_data   <= pick_data;
            burst_cnt <= BW'(1);
            wd_cnt    <= '0;
          end
        end
        ST_WAIT: begin
          // Completion outranks a coincident watchdog expiry.
          if (tx_done && cont) begin
            req_ready <= grant;
            tx_enb    <= 1'b1;
            tx_data   <= own_data;
            burst_cnt <= burst_cnt + 1'b1;
            wd_cnt    <= '0;
          end else if (tx_done || wd_expire) begin
            err_timeout <= !tx_done;
            state       <= ST_IDLE;
            busy        <= 1'b0;
            grant       <= '0;
            ptr         <= nxt_ptr;
          end else if (!(&wd_cnt)) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a transaction-level
// arbiter model predicts every start and watchdog event.
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           tx_enb;
  logic [7:0]     tx_data;
  logic           tx_done = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;
  logic           err_timeout;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .N_REQ    (N),
    .MAX_BURST(MB),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_enb     (tx_enb),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .grant      (grant),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  typedef struct {
    int         cyc;
    int         idx;
    logic [7:0] data;
  } start_t;

  start_t     sq[$];
  int         eq[$];
  logic [7:0] pq[N][$];

  int n_vec = 0, n_err = 0, cyc = 0;
  int n_push = 0, n_clr = 0, n_seen = 0, n_errto = 0;
  int td_mode = 0, td_cnt = 0, td_d = 0;
  bit drop_en = 0;

  // reference model state
  bit         m_busy = 0, m_hit = 0;
  int         m_own = 0, m_ptr = 0, m_nb = 0, m_t0 = 0;
  logic [7:0] m_txd = '0;
  start_t     ms;
  int         me;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  task automatic m_start(input int j, input int nb);
    sq.push_back('{cyc, j, req_data[8*j +: 8]});
    m_txd  = req_data[8*j +: 8];
    m_own  = j;
    m_nb   = nb;
    m_busy = 1;
    m_t0   = cyc;
  endtask

  task automatic m_release();
    m_ptr  = (m_own + 1) % N;
    m_busy = 0;
  endtask

  // Model: one grant at a time, rotating from m_ptr, bursts capped.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0;
      m_ptr  = 0;
      m_txd  = '0;
      sq.delete();
      eq.delete();
    end else if (!m_busy) begin
      m_hit = 0;
      for (int k = 0; k < N; k++) begin
        if (!m_hit && req_valid[(m_ptr + k) % N]) begin
          m_hit = 1;
          m_start((m_ptr + k) % N, 1);
        end
      end
    end else if (tx_done) begin
      if (req_valid[m_own] && m_nb < MB) m_start(m_own, m_nb + 1);
      else m_release();
    end else if (cyc - m_t0 == TO) begin
      eq.push_back(cyc);
      m_release();
    end
  end

  // Monitor, producers and transmitter stand-in.
  always @(negedge clk) begin
    chk("grant", grant, m_busy ? oh(m_own) : '0);
    chk("busy", busy, m_busy);
    chk("tx_data", tx_data, m_txd);
    if (tx_enb) begin
      if (sq.size() == 0) chk("unexpected_tx_enb", tx_enb, 0);
      else begin
        ms = sq.pop_front();
        n_seen++;
        chk("start_cycle", cyc, ms.cyc);
        chk("req_ready", req_ready, oh(ms.idx));
      end
    end else begin
      chk("req_ready_quiet", req_ready, 0);
      if (sq.size() > 0 && sq[0].cyc <= cyc) begin
        void'(sq.pop_front());
        chk("missing_tx_enb", tx_enb, 1);
      end
    end
    if (err_timeout) begin
      n_errto++;
      if (eq.size() == 0) chk("unexpected_err", err_timeout, 0);
      else begin
        me = eq.pop_front();
        chk("err_cycle", cyc, me);
      end
    end else if (eq.size() > 0 && eq[0] <= cyc) begin
      void'(eq.pop_front());
      chk("missing_err", err_timeout, 1);
    end

    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      req_valid[i] = (pq[i].size() > 0)
                   && !(drop_en && $urandom_range(4) == 0);
      req_data[8*i +: 8] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
    end

    tx_done = 1'b0;
    if (td_cnt > 0) begin
      td_cnt--;
      if (td_cnt == 0) tx_done = 1'b1;
    end
    if (tx_enb) begin
      td_d = (td_mode == 0) ? int'($urandom_range(6, 2))
           : (td_mode == 2) ? TO : 0;
      td_cnt = (td_d > 0) ? td_d - 1 : 0;
    end
  end

  task automatic push(input int i, input logic [7:0] b);
    pq[i].push_back(b);
    n_push++;
  endtask

  task automatic wait_drain(input string nm);
    int t;
    bit pend;
    t = 0;
    pend = 1;
    while (pend && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
      pend = m_busy || td_cnt > 0;
      for (int i = 0; i < N; i++) if (pq[i].size() > 0) pend = 1;
    end
    n_vec++;
    if (pend) begin
      n_err++;
      $display("FAIL drain_%s: still active after %0d cycles, expected idle",
               nm, t);
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  int seen0, t;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_enb", tx_enb, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;

    push(0, 8'hA5);
    wait_drain("single");
    chk("single_hold", tx_data, 8'hA5);
    chk("single_grant", grant, 0);

    for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i));
    wait_drain("fair");

    for (int k = 0; k < 6; k++) push(2, 8'h20 + 8'(k));
    push(0, 8'h30);
    wait_drain("burst");

    td_mode = 1;
    push(1, 8'h41);
    push(3, 8'h43);
    wait_drain("watchdog");
    chk("watchdog_count", n_errto, 2);

    td_mode = 2;
    push(3, 8'h51);
    push(3, 8'h52);
    wait_drain("tie");
    chk("tie_no_err", n_errto, 2);
    td_mode = 0;

    for (int k = 0; k < 4; k++) push(1, 8'h60 + 8'(k));
    t = 0;
    while (!m_busy && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("midburst_started", busy, 1);
    rst = 1'b1;
    n_clr += pq[1].size();
    pq[1].delete();
    seen0 = n_seen;
    @(negedge clk);
    #1;
    chk("midrst_grant", grant, 0);
    chk("midrst_tx_enb", tx_enb, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("late_done_no_enb", n_seen, seen0);

    drop_en = 1;
    repeat (800) begin
      @(negedge clk);
      #1;
      if ($urandom_range(2) == 0) begin
        t = int'($urandom_range(N - 1));
        if (pq[t].size() < 6) push(t, 8'($urandom));
      end
      t = int'($urandom_range(19));
      td_mode = (t == 0) ? 1 : (t == 1) ? 2 : 0;
    end
    drop_en = 0;
    td_mode = 0;
    wait_drain("random");

    chk("bytes_delivered", n_seen, n_push - n_clr);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
